// File: rtl/rca_chunk_sequencer_if.sv
// rtl/rca_chunk_sequencer_if.sv - operand request, result and adder-drive signals of the chunk sequencer
`timescale 1ns/1ps

interface rca_chunk_sequencer_if #(
  parameter int CHUNKS = 4
);
  localparam int SUM_W = 5 * CHUNKS;

  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] a;
  logic [SUM_W-1:0] b;
  logic             cin_in;

  logic [4:0]       add_p;
  logic [4:0]       add_q;
  logic             add_cin;
  logic [5:0]       add_r;

  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
  logic             cout;

  // master is the sequencer; slave is the requester, consumer and adder around it
  modport master (
    input  in_valid, a, b, cin_in, add_r, out_ready,
    output in_ready, add_p, add_q, add_cin, out_valid, sum, cout
  );

  modport slave (
    output in_valid, a, b, cin_in, add_r, out_ready,
    input  in_ready, add_p, add_q, add_cin, out_valid, sum, cout
  );
endinterface

// File: rtl/rca_chunk_sequencer.sv
// rtl/rca_chunk_sequencer.sv - wide add through an external 5-bit ripple-carry adder, one chunk per cycle
`timescale 1ns/1ps

module rca_chunk_sequencer #(
  parameter int CHUNKS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rca_chunk_sequencer_if.master bus
);
  localparam int SUM_W = 5 * CHUNKS;
  localparam int IW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [SUM_W-1:0] a_q;
  logic [SUM_W-1:0] b_q;
  logic [SUM_W-1:0] sum_q;
  logic             carry_q;

  logic [4:0]       a_chunk;
  logic [4:0]       b_chunk;
  logic             in_run;
  logic             in_done;
  logic             in_idle;

  // chunk select as a mux over whole chunks keeps idx free of width-extended arithmetic
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_q[5*i +: 5];
        b_chunk = b_q[5*i +: 5];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin_in;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < CHUNKS; i++) begin
            if (idx == IW'(i)) begin
              sum_q[5*i +: 5] <= bus.add_r[4:0];
            end
          end
          carry_q <= bus.add_r[5];
          if (idx == IW'(CHUNKS - 1)) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // every output is forced low while reset is asserted, independent of the state register
  assign in_idle = !rst && (state == IDLE);
  assign in_run  = !rst && (state == RUN);
  assign in_done = !rst && (state == DONE);

  assign bus.in_ready  = in_idle;
  assign bus.add_p     = in_run  ? a_chunk : 5'd0;
  assign bus.add_q     = in_run  ? b_chunk : 5'd0;
  assign bus.add_cin   = in_run  ? carry_q : 1'b0;
  assign bus.out_valid = in_done;
  assign bus.sum       = in_done ? sum_q   : '0;
  assign bus.cout      = in_done ? carry_q : 1'b0;

endmodule

// File: tb/tb_rca_chunk_sequencer.sv
// tb/tb_rca_chunk_sequencer.sv - directed and randomized bench for the chunk sequencer, CHUNKS=4 and CHUNKS=1
`timescale 1ns/1ps

module tb_rca_chunk_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rca_chunk_sequencer_if #(.CHUNKS(4)) d4 ();
  rca_chunk_sequencer_if #(.CHUNKS(1)) d1 ();

  rca_chunk_sequencer #(.CHUNKS(4)) dut4 (.clk(clk), .rst(rst), .bus(d4.master));
  rca_chunk_sequencer #(.CHUNKS(1)) dut1 (.clk(clk), .rst(rst), .bus(d1.master));

  // 5-bit ripple-carry adder behaviour
  assign d4.add_r = 6'(d4.add_p) + 6'(d4.add_q) + 6'(d4.add_cin);
  assign d1.add_r = 6'(d1.add_p) + 6'(d1.add_q) + 6'(d1.add_cin);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [19:0] a, input logic [19:0] b, input logic c,
                       input int hold, input bit keep, output bit cin_all);
    logic [20:0] exp;
    logic [20:0] seen;
    int          lat;
    bit          rdy_seen;
    exp = 21'(a) + 21'(b) + 21'(c);
    d4.a = a;
    d4.b = b;
    d4.cin_in = c;
    d4.in_valid = 1'b1;
    d4.out_ready = (hold == 0);
    #1;
    check({tag, "_in_ready"}, 32'(d4.in_ready), 32'd1);
    tick();
    if (!keep) d4.in_valid = 1'b0;
    #1;
    lat = 0;
    cin_all = 1'b1;
    rdy_seen = 1'b0;
    while (!d4.out_valid && lat < 20) begin
      cin_all &= d4.add_cin;
      rdy_seen |= d4.in_ready;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_result"}, 32'({d4.cout, d4.sum}), 32'(exp));
    check({tag, "_busy_in_ready"}, 32'(rdy_seen), 32'd0);
    seen = {d4.cout, d4.sum};
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(d4.out_valid), 32'd1);
      check({tag, "_hold_value"}, 32'({d4.cout, d4.sum}), 32'(seen));
      check({tag, "_hold_in_ready"}, 32'(d4.in_ready), 32'd0);
    end
    d4.out_ready = 1'b1;
    #1;
    tick();
    check({tag, "_after_valid"}, 32'(d4.out_valid), 32'd0);
    check({tag, "_after_in_ready"}, 32'(d4.in_ready), 32'd1);
    check({tag, "_idle_adder"}, 32'({d4.add_p, d4.add_q, d4.add_cin}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          cin_all;
    logic [20:0] q4[$];
    logic [5:0]  q1[$];
    logic [20:0] e4;
    logic [5:0]  e1;
    logic [20:0] held_val4;
    bit          held4, acc4, acc1;
    int          iss4, iss1, got4, got1, cyc;

    d4.in_valid = 0; d4.a = 0; d4.b = 0; d4.cin_in = 0; d4.out_ready = 0;
    d1.in_valid = 0; d1.a = 0; d1.b = 0; d1.cin_in = 0; d1.out_ready = 0;

    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready", 32'(d4.in_ready), 32'd0);
    check("rst_out_valid", 32'(d4.out_valid), 32'd0);
    check("rst_sum", 32'(d4.sum), 32'd0);
    check("rst_cout", 32'(d4.cout), 32'd0);
    check("rst_adder", 32'({d4.add_p, d4.add_q, d4.add_cin}), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(d4.in_ready), 32'd1);

    do_op("simple", 20'h00001, 20'h00001, 1'b0, 0, 1'b0, cin_all);

    do_op("ripple", 20'hFFFFF, 20'h00000, 1'b1, 0, 1'b0, cin_all);
    check("ripple_add_cin_all", 32'(cin_all), 32'd1);

    // backpressure with a request held throughout; the follow-up is accepted only once back in IDLE
    do_op("bp", 20'hFFFFF, 20'hFFFFF, 1'b1, 5, 1'b1, cin_all);
    do_op("bp_next", 20'h00003, 20'h00004, 1'b0, 0, 1'b0, cin_all);

    // abort in the middle of RUN
    d4.a = 20'h12345; d4.b = 20'h54321; d4.cin_in = 1'b0; d4.in_valid = 1'b1; d4.out_ready = 1'b1;
    #1;
    tick();
    d4.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_rst_valid", 32'(d4.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", 32'(d4.out_valid), 32'd0);
    end
    do_op("abort_next", 20'h0A5A5, 20'h05A5A, 1'b0, 0, 1'b0, cin_all);

    // random traffic on both builds against an arithmetic scoreboard
    iss4 = 0; iss1 = 0; got4 = 0; got1 = 0; cyc = 0;
    held4 = 1'b0; held_val4 = '0;
    d4.in_valid = 1'b0; d1.in_valid = 1'b0;
    while ((got4 < 1000 || got1 < 1000) && cyc < 40000) begin
      if (!d4.in_valid && iss4 < 1000 && $urandom_range(1, 0) != 0) begin
        d4.a = 20'($urandom); d4.b = 20'($urandom); d4.cin_in = 1'($urandom); d4.in_valid = 1'b1;
      end
      if (!d1.in_valid && iss1 < 1000 && $urandom_range(1, 0) != 0) begin
        d1.a = 5'($urandom); d1.b = 5'($urandom); d1.cin_in = 1'($urandom); d1.in_valid = 1'b1;
      end
      d4.out_ready = ($urandom_range(3, 0) != 0);
      d1.out_ready = ($urandom_range(3, 0) != 0);
      #1;
      acc4 = d4.in_valid && d4.in_ready;
      acc1 = d1.in_valid && d1.in_ready;
      if (acc4) begin
        q4.push_back(21'(d4.a) + 21'(d4.b) + 21'(d4.cin_in));
        iss4++;
      end
      if (acc1) begin
        q1.push_back(6'(d1.a) + 6'(d1.b) + 6'(d1.cin_in));
        iss1++;
      end
      if (held4) begin
        check("rnd4_hold_valid", 32'(d4.out_valid), 32'd1);
        check("rnd4_hold_value", 32'({d4.cout, d4.sum}), 32'(held_val4));
      end
      held4 = d4.out_valid && !d4.out_ready;
      held_val4 = {d4.cout, d4.sum};
      if (d4.out_valid && d4.out_ready) begin
        if (q4.size() == 0) check("rnd4_extra_result", 32'd1, 32'd0);
        else begin
          e4 = q4.pop_front();
          check("rnd4_result", 32'({d4.cout, d4.sum}), 32'(e4));
        end
        got4++;
      end
      if (d1.out_valid && d1.out_ready) begin
        if (q1.size() == 0) check("rnd1_extra_result", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          check("rnd1_result", 32'({d1.cout, d1.sum}), 32'(e1));
        end
        got1++;
      end
      tick();
      if (acc4) d4.in_valid = 1'b0;
      if (acc1) d1.in_valid = 1'b0;
      cyc++;
    end
    check("rnd4_count", 32'(got4), 32'd1000);
    check("rnd1_count", 32'(got1), 32'd1000);
    check("rnd4_leftover", 32'(q4.size()), 32'd0);
    check("rnd1_leftover", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
